// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues one load/store per instruction over a
// req/ready + rvalid port and returns a single-cycle completion with writeback data.
module mem_access #(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enabled,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] exec_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        completed,
    output logic [31:0] result,
    output logic [4:0]  rd_out,
    output logic        fault,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam bit          TMO_EN   = TIMEOUT_CYCLES > 0;
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;
    logic [31:0] tcnt;

    logic        is_mem;
    logic        illegal;
    logic        misaligned;
    logic        tmo;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] shifted;
    logic [31:0] load_val;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        is_mem     = is_load | is_store;
        illegal    = is_load ? (funct3 == 3'b011 || funct3[2:1] == 2'b11)
                             : (funct3 >= 3'b011);
        misaligned = (funct3[1:0] == 2'b01 && exec_result[0]) ||
                     (funct3[1:0] == 2'b10 && exec_result[1:0] != 2'b00);
        strb  = 4'b1111;
        wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                strb  = 4'b0001 << exec_result[1:0];
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                strb  = 4'b0011 << exec_result[1:0];
                wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
        if (!is_store) strb = 4'b0000;

        // Bring the addressed byte/half down to bit 0, then extend per width code.
        shifted  = mem_rdata >> {off_q, 3'b000};
        load_val = mem_rdata;
        case (f3_q)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_val = {24'd0, shifted[7:0]};
            3'b101:  load_val = {16'd0, shifted[15:0]};
            default: ;
        endcase

        tmo = TMO_EN && (tcnt == TMO_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            completed <= 1'b0;
            result    <= '0;
            rd_out    <= '0;
            fault     <= 1'b0;
            busy      <= 1'b0;
            off_q     <= '0;
            f3_q      <= '0;
            rd_q      <= '0;
            tcnt      <= '0;
        end else begin
            completed <= 1'b0;
            case (state)
                IDLE: if (enabled) begin
                    busy <= 1'b1;
                    if (!is_mem || illegal || misaligned) begin
                        state     <= DONE;
                        completed <= 1'b1;
                        result    <= is_mem ? 32'd0 : exec_result;
                        rd_out    <= rd_in;
                        fault     <= is_mem;
                    end else begin
                        state     <= REQ;
                        mem_req   <= 1'b1;
                        mem_we    <= is_store;
                        mem_addr  <= {exec_result[31:2], 2'b00};
                        mem_wdata <= wdata;
                        mem_wstrb <= strb;
                        rd_q      <= rd_in;
                        off_q     <= exec_result[1:0];
                        f3_q      <= funct3;
                        tcnt      <= '0;
                    end
                end
                REQ: begin
                    // Handshake is tested before the timeout so it wins a tie.
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        tcnt    <= '0;
                        if (mem_we) begin
                            state     <= DONE;
                            completed <= 1'b1;
                            result    <= '0;
                            rd_out    <= rd_q;
                            fault     <= 1'b0;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (tmo) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        state     <= DONE;
                        completed <= 1'b1;
                        result    <= '0;
                        rd_out    <= rd_q;
                        fault     <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 32'd1;
                    end
                end
                WAIT: begin
                    if (mem_rvalid || tmo) begin
                        state     <= DONE;
                        completed <= 1'b1;
                        result    <= mem_rvalid ? load_val : 32'd0;
                        rd_out    <= rd_q;
                        fault     <= !mem_rvalid;
                    end else begin
                        tcnt <= tcnt + 32'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: pass-through, store lanes, load extension,
// faults, timeout (TIMEOUT_CYCLES=4) and reset in the middle of a load.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enabled = 1'b0;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] exec_result = '0;
    logic [31:0] store_data = '0;
    logic [4:0]  rd_in = '0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        completed;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        fault;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rstn(rstn), .enabled(enabled), .is_load(is_load), .is_store(is_store),
        .funct3(funct3), .exec_result(exec_result), .store_data(store_data), .rd_in(rd_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .completed(completed), .result(result), .rd_out(rd_out),
        .fault(fault), .busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle enabled pulse; returns just after the sampling edge.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd);
        is_load = ld; is_store = st; funct3 = f3;
        exec_result = addr; store_data = data; rd_in = rd;
        enabled = 1'b1;
        step();
        enabled = 1'b0; is_load = 1'b0; is_store = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({mem_req, mem_we, completed, fault, busy} !== 5'b0) begin
            n_bad++; $display("FAIL reset_flags: got %b exp 00000", {mem_req, mem_we, completed, fault, busy});
        end
        n_cmp++;
        if ({result, mem_addr, mem_wdata} !== 96'd0) begin
            n_bad++; $display("FAIL reset_data: got %h %h %h exp 0", result, mem_addr, mem_wdata);
        end
        n_cmp++;
        if ({rd_out, mem_wstrb} !== 9'd0) begin
            n_bad++; $display("FAIL reset_rd_strb: got %h %h exp 0", rd_out, mem_wstrb);
        end
    endtask

    task automatic test_pass_through(input logic [31:0] val, input logic [4:0] rd);
        issue(1'b0, 1'b0, 3'b010, val, 32'h0, rd);
        n_cmp++;
        if ({completed, fault, mem_req, busy} !== 4'b1001) begin
            n_bad++; $display("FAIL pass_flags: got %b exp 1001", {completed, fault, mem_req, busy});
        end
        n_cmp++;
        if (result !== val || rd_out !== rd) begin
            n_bad++; $display("FAIL pass_data: got %h/%0d exp %h/%0d", result, rd_out, val, rd);
        end
        step();
        n_cmp++;
        if ({completed, busy, mem_req} !== 3'b000) begin
            n_bad++; $display("FAIL pass_end: got %b exp 000", {completed, busy, mem_req});
        end
    endtask

    task automatic test_store();
        issue(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'hAABB_CCDD, 5'd7);
        n_cmp++;
        if ({mem_req, mem_we, mem_wstrb, completed} !== 7'b11_1000_0) begin
            n_bad++; $display("FAIL sb_ctrl: got %b exp 1110000", {mem_req, mem_we, mem_wstrb, completed});
        end
        n_cmp++;
        if (mem_addr !== 32'h100 || mem_wdata !== 32'hDDDD_DDDD) begin
            n_bad++; $display("FAIL sb_addr_data: got %h %h exp 00000100 dddddddd", mem_addr, mem_wdata);
        end
        // Upstream keeps pulsing enabled while busy; it must be dropped.
        enabled = 1'b1; rd_in = 5'd31; exec_result = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({mem_req, mem_we, completed} !== 3'b110 || mem_addr !== 32'h100 || mem_wstrb !== 4'b1000) begin
                n_bad++; $display("FAIL sb_hold%0d: got %b %h %b", i, {mem_req, mem_we, completed}, mem_addr, mem_wstrb);
            end
        end
        enabled = 1'b0;
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        n_cmp++;
        if ({completed, mem_req, fault} !== 3'b100 || result !== 32'd0 || rd_out !== 5'd7) begin
            n_bad++; $display("FAIL sb_done: got %b %h %0d exp 100 0 7", {completed, mem_req, fault}, result, rd_out);
        end
        step();
        step();
        n_cmp++;
        if ({completed, busy} !== 2'b00 || rd_out !== 5'd7) begin
            n_bad++; $display("FAIL sb_ignored_enable: got %b rd %0d exp 00 rd 7", {completed, busy}, rd_out);
        end
    endtask

    task automatic test_load(input string name, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] exp);
        issue(1'b1, 1'b0, f3, addr, 32'h0, 5'd3);
        n_cmp++;
        if ({mem_req, mem_we, mem_wstrb} !== 6'b10_0000 || mem_addr !== {addr[31:2], 2'b00}) begin
            n_bad++; $display("FAIL %s_req: got %b %h", name, {mem_req, mem_we, mem_wstrb}, mem_addr);
        end
        // rvalid in the accept cycle carries junk and must not be sampled.
        mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        step();
        n_cmp++;
        if ({mem_req, completed, busy} !== 3'b001) begin
            n_bad++; $display("FAIL %s_wait: got %b exp 001", name, {mem_req, completed, busy});
        end
        mem_rvalid = 1'b1; mem_rdata = 32'h80FF_7F01;
        step();
        mem_rvalid = 1'b0;
        n_cmp++;
        if ({completed, fault} !== 2'b10 || result !== exp || rd_out !== 5'd3) begin
            n_bad++; $display("FAIL %s_data: got %b %h exp 10 %h", name, {completed, fault}, result, exp);
        end
        step();
    endtask

    task automatic test_faults();
        logic [2:0]  f3s [3] = '{3'b010, 3'b011, 3'b001};
        logic        sts [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] ads [3] = '{32'h102, 32'h100, 32'h201};
        for (int i = 0; i < 3; i++) begin
            issue(!sts[i], sts[i], f3s[i], ads[i], 32'h1234_5678, 5'd4);
            n_cmp++;
            if ({completed, fault, mem_req} !== 3'b110 || result !== 32'd0) begin
                n_bad++; $display("FAIL fault%0d: got %b %h exp 110 0", i, {completed, fault, mem_req}, result);
            end
            step();
        end
    endtask

    task automatic test_timeout();
        // rvalid on the 4th WAIT cycle: handshake beats the timeout.
        issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd6);
        mem_ready = 1'b1; step(); mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        mem_rvalid = 1'b1; mem_rdata = 32'h1122_3344;
        step();
        mem_rvalid = 1'b0;
        n_cmp++;
        if ({completed, fault} !== 2'b10 || result !== 32'h1122_3344) begin
            n_bad++; $display("FAIL tmo_tie: got %b %h exp 10 11223344", {completed, fault}, result);
        end
        step();
        // No rvalid at all: abort after 4 cycles in WAIT.
        issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd6);
        mem_ready = 1'b1; step(); mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        n_cmp++;
        if (completed !== 1'b0) begin
            n_bad++; $display("FAIL tmo_early: got completed %b exp 0", completed);
        end
        step();
        n_cmp++;
        if ({completed, fault} !== 2'b11 || result !== 32'd0 || rd_out !== 5'd6) begin
            n_bad++; $display("FAIL tmo_wait: got %b %h %0d exp 11 0 6", {completed, fault}, result, rd_out);
        end
        step();
        // Store never accepted: abort from REQ with mem_req dropped.
        test_pass_through(32'h0BAD_F00D, 5'd1);
        issue(1'b0, 1'b1, 3'b010, 32'h400, 32'h9, 5'd8);
        for (int i = 0; i < 4; i++) step();
        n_cmp++;
        if ({completed, fault, mem_req} !== 3'b110 || result !== 32'd0) begin
            n_bad++; $display("FAIL tmo_req: got %b %h exp 110 0", {completed, fault, mem_req}, result);
        end
        step();
    endtask

    task automatic test_reset_mid_op();
        test_pass_through(32'h5A5A_5A5A, 5'd2);
        issue(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 5'd10);
        mem_ready = 1'b1; step(); mem_ready = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL rst_pre_busy: got %b exp 1", busy);
        end
        #2 rstn = 1'b0;
        #1;
        n_cmp++;
        if ({mem_req, busy, completed} !== 3'b000 || result !== 32'd0 || rd_out !== 5'd0) begin
            n_bad++; $display("FAIL rst_async: got %b %h %0d exp 000 0 0", {mem_req, busy, completed}, result, rd_out);
        end
        @(negedge clk);
        rstn = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
        step();
        step();
        mem_rvalid = 1'b0;
        n_cmp++;
        if ({completed, busy} !== 2'b00 || result !== 32'd0) begin
            n_bad++; $display("FAIL rst_late_rvalid: got %b %h exp 00 0", {completed, busy}, result);
        end
        test_pass_through(32'hCAFE_F00D, 5'd9);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rstn = 1'b1;
        step();
        test_pass_through(32'h1234_5678, 5'd5);
        test_store();
        test_load("lb",  3'b000, 32'h201, 32'h0000_007F);
        test_load("lbu", 3'b100, 32'h203, 32'h0000_0080);
        test_load("lh",  3'b001, 32'h202, 32'hFFFF_80FF);
        test_load("lhu", 3'b101, 32'h200, 32'h0000_7F01);
        test_load("lw",  3'b010, 32'h200, 32'h80FF_7F01);
        test_faults();
        test_timeout();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
